// File: rtl/accel_irq_ctrl.sv
// Completion interrupt / event controller for the accelerator: run-time counter, sticky flags,
// irq handshake. Optional run watchdog enabled by defining ACCEL_IRQ_WATCHDOG_EN.
module accel_irq_ctrl #(
    parameter int CNT_WIDTH      = 32,
    parameter int ERR_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 done,
    input  logic [ERR_WIDTH-1:0] accel_error,
    input  logic                 irq_en,
    input  logic                 irq_ack,
    output logic                 irq_o,
    output logic                 evt_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] run_cycles_o,
    output logic [ERR_WIDTH-1:0] err_o,
    output logic                 timeout_o,
    output logic                 spurious_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   start_q, start_d;
    logic                   irq_q, irq_d;
    logic                   evt_q, evt_d;
    logic                   busy_q, busy_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d;
    logic                   timeout_q, timeout_d;
    logic                   spurious_q, spurious_d;
    logic                   start_rise_s;
    logic                   wd_hit_s;

`ifdef ACCEL_IRQ_WATCHDOG_EN
    localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    assign start_rise_s = start & ~start_q;

    // Watchdog compares the pre-increment count so the limit cycle itself is counted.
    always_comb begin
`ifdef ACCEL_IRQ_WATCHDOG_EN
        wd_hit_s = (state_q == ST_RUN) && (cnt_q == WD_LIMIT);
`else
        wd_hit_s = 1'b0;
`endif
    end

    // Next-state and next-output computation for the IDLE/RUN/PEND controller.
    always_comb begin
        state_d    = state_q;
        start_d    = start;
        irq_d      = irq_q;
        evt_d      = 1'b0;
        cnt_d      = cnt_q;
        err_d      = err_q;
        timeout_d  = timeout_q;
        spurious_d = spurious_q;
        case (state_q)
            ST_IDLE: begin
                if (done) begin
                    spurious_d = 1'b1;
                end else begin
                    spurious_d = spurious_q;
                end
                if (start_rise_s) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    err_d     = '0;
                    timeout_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_d = sat_inc(cnt_q);
                if (done) begin
                    state_d = ST_PEND;
                    err_d   = accel_error;
                    evt_d   = 1'b1;
                    irq_d   = irq_en;
                end else if (wd_hit_s) begin
                    state_d   = ST_PEND;
                    timeout_d = 1'b1;
                    evt_d     = 1'b1;
                    irq_d     = irq_en;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                if (irq_ack) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            irq_q      <= 1'b0;
            evt_q      <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            err_q      <= '0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            irq_q      <= irq_d;
            evt_q      <= evt_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
            spurious_q <= spurious_d;
        end
    end

    assign irq_o        = irq_q;
    assign evt_o        = evt_q;
    assign busy_o       = busy_q;
    assign run_cycles_o = cnt_q;
    assign err_o        = err_q;
    assign timeout_o    = timeout_q;
    assign spurious_o   = spurious_q;

endmodule
